// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB arbiter and its per-source result queues.
// Source-select encodings match the cdb_src output.
package cdb_arbiter_pkg;

    localparam int   ROB_SIZE_WIDTH  = 4;
    localparam int   CDB_QUEUE_DEPTH = 2;
    localparam logic CDB_SRC_ALU     = 1'b0;
    localparam logic CDB_SRC_MEM     = 1'b1;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cdb_queue.sv
// Small circular result buffer feeding one CDB source.
// Pushes while full and pops while empty are ignored.
module cdb_queue
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 36
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             en_in,
    input  logic             flush_in,
    input  logic             push_in,
    input  logic             pop_in,
    input  logic [WIDTH-1:0] push_data_in,
    output logic [WIDTH-1:0] head_data_out,
    output logic             empty_out,
    output logic             full_out
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_out     = (count_q == '0);
    assign full_out      = (count_q == CW'(DEPTH));
    assign head_data_out = mem_q[head_q];
    assign push_ok       = push_in && !full_out;
    assign pop_ok        = pop_in && !empty_out;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (en_in) begin
            if (flush_in) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (push_ok) begin
                    mem_d[tail_q] = push_data_in;
                    tail_d        = next_ptr(tail_q);
                end
                if (pop_ok) begin
                    head_d = next_ptr(head_q);
                end
                case ({push_ok, pop_ok})
                    2'b10:   count_d = count_q + CW'(1);
                    2'b01:   count_d = count_q - CW'(1);
                    default: count_d = count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset; count gates every read.
    always_ff @(posedge clk_in) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the registered CDB between ALU and memory.
// Each source has a result queue; an empty queue lets its input bypass.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int QUEUE_DEPTH  = CDB_QUEUE_DEPTH,
    parameter int ROB_ID_WIDTH = ROB_SIZE_WIDTH
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    need_flush_in,
    input  logic                    alu_valid,
    input  logic [31:0]             alu_value,
    input  logic [ROB_ID_WIDTH-1:0] alu_rob_id,
    input  logic                    mem_valid,
    input  logic [31:0]             mem_value,
    input  logic [ROB_ID_WIDTH-1:0] mem_rob_id,
    output logic                    alu_full_out,
    output logic                    mem_full_out,
    output logic                    cdb_valid,
    output logic [31:0]             cdb_value,
    output logic [ROB_ID_WIDTH-1:0] cdb_rob_id,
    output logic                    cdb_src,
    output logic                    overflow_err
);

    localparam int EW = 32 + ROB_ID_WIDTH;

    logic [EW-1:0] alu_head, mem_head, grant_data;
    logic          alu_empty, mem_empty;
    logic          alu_cand, mem_cand;
    logic          grant_any, grant_mem;
    logic          alu_push, alu_pop, mem_push, mem_pop;

    logic                    cdb_valid_q, cdb_valid_d;
    logic [31:0]             cdb_value_q, cdb_value_d;
    logic [ROB_ID_WIDTH-1:0] cdb_rob_id_q, cdb_rob_id_d;
    logic                    cdb_src_q, cdb_src_d;
    logic                    last_grant_q, last_grant_d;
    logic                    overflow_q, overflow_d;

    always_comb begin
        alu_cand  = !alu_empty || alu_valid;
        mem_cand  = !mem_empty || mem_valid;
        grant_any = alu_cand || mem_cand;
        if (alu_cand && mem_cand) begin
            grant_mem = (last_grant_q == CDB_SRC_ALU);
        end else begin
            grant_mem = mem_cand;
        end
        alu_pop  = grant_any && !grant_mem && !alu_empty;
        mem_pop  = grant_mem && !mem_empty;
        // Bypass only when the queue is empty, keeping per-source order.
        alu_push = alu_valid && !(grant_any && !grant_mem && alu_empty);
        mem_push = mem_valid && !(grant_mem && mem_empty);
        if (grant_mem) begin
            grant_data = mem_empty ? {mem_value, mem_rob_id} : mem_head;
        end else begin
            grant_data = alu_empty ? {alu_value, alu_rob_id} : alu_head;
        end
    end

    always_comb begin
        cdb_valid_d  = cdb_valid_q;
        cdb_value_d  = cdb_value_q;
        cdb_rob_id_d = cdb_rob_id_q;
        cdb_src_d    = cdb_src_q;
        last_grant_d = last_grant_q;
        overflow_d   = overflow_q;
        if (rdy_in) begin
            if (need_flush_in) begin
                cdb_valid_d  = 1'b0;
                last_grant_d = CDB_SRC_MEM;
            end else begin
                cdb_valid_d = grant_any;
                if (grant_any) begin
                    cdb_value_d  = grant_data[EW-1:ROB_ID_WIDTH];
                    cdb_rob_id_d = grant_data[ROB_ID_WIDTH-1:0];
                    cdb_src_d    = grant_mem;
                    last_grant_d = grant_mem;
                end
                if ((alu_valid && alu_full_out) || (mem_valid && mem_full_out)) begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cdb_valid_q  <= 1'b0;
            cdb_value_q  <= '0;
            cdb_rob_id_q <= '0;
            cdb_src_q    <= CDB_SRC_ALU;
            last_grant_q <= CDB_SRC_MEM;
            overflow_q   <= 1'b0;
        end else begin
            cdb_valid_q  <= cdb_valid_d;
            cdb_value_q  <= cdb_value_d;
            cdb_rob_id_q <= cdb_rob_id_d;
            cdb_src_q    <= cdb_src_d;
            last_grant_q <= last_grant_d;
            overflow_q   <= overflow_d;
        end
    end

    cdb_queue #(.DEPTH(QUEUE_DEPTH), .WIDTH(EW)) u_alu_q (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .en_in         (rdy_in),
        .flush_in      (need_flush_in),
        .push_in       (alu_push),
        .pop_in        (alu_pop),
        .push_data_in  ({alu_value, alu_rob_id}),
        .head_data_out (alu_head),
        .empty_out     (alu_empty),
        .full_out      (alu_full_out)
    );

    cdb_queue #(.DEPTH(QUEUE_DEPTH), .WIDTH(EW)) u_mem_q (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .en_in         (rdy_in),
        .flush_in      (need_flush_in),
        .push_in       (mem_push),
        .pop_in        (mem_pop),
        .push_data_in  ({mem_value, mem_rob_id}),
        .head_data_out (mem_head),
        .empty_out     (mem_empty),
        .full_out      (mem_full_out)
    );

    assign cdb_valid    = cdb_valid_q;
    assign cdb_value    = cdb_value_q;
    assign cdb_rob_id   = cdb_rob_id_q;
    assign cdb_src      = cdb_src_q;
    assign overflow_err = overflow_q;

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single result broadcast bus (CDB) between the ALU and the memory unit. Each producer gets a small result queue; every cycle the arbiter grants one head (or one bypassed input) round-robin and registers it onto the CDB, which feeds the reservation stations, the load/store buffer and the ROB. Backpressure goes to each producer through a per-source full flag. The block clears on a pipeline flush.

## Interface
- `QUEUE_DEPTH`, default 2: entries per source queue; must be ≥1 and a power of two.
- `ROB_ID_WIDTH`, default `` `ROB_SIZE_WIDTH ``: width of the ROB tag.
- `clk_in`  in  1  clock, rising edge.
- `rst_in`  in  1  synchronous, active-high reset.
- `rdy_in`  in  1  global enable; low means hold all state.
- `need_flush_in`  in  1  mispredict flush.
- `alu_valid`  in  1  ALU result present this cycle.
- `alu_value`  in  32  ALU result.
- `alu_rob_id`  in  ROB_ID_WIDTH  ROB tag of the ALU result.
- `mem_valid`  in  1  memory result present this cycle.
- `mem_value`  in  32  memory result.
- `mem_rob_id`  in  ROB_ID_WIDTH  ROB tag of the memory result.
- `alu_full_out`  out  1  combinational; ALU queue count == QUEUE_DEPTH.
- `mem_full_out`  out  1  combinational; memory queue count == QUEUE_DEPTH.
- `cdb_valid`  out  1  registered broadcast valid.
- `cdb_value`  out  32  registered broadcast value.
- `cdb_rob_id`  out  ROB_ID_WIDTH  registered broadcast tag.
- `cdb_src`  out  1  0 = ALU, 1 = memory.
- `overflow_err`  out  1  sticky flag; a push arrived while the queue was full.

## Operation
- **Candidate per source.** It is the queue head if the queue is non-empty. Otherwise it is the live input if `*_valid` is high (bypass). Otherwise there is no candidate.
- **Grant.**
  - Exactly one candidate: grant it.
  - Two candidates: grant the source not granted last. This uses a 1-bit `last_grant` register, updated on every grant.
- **Granted candidate.** It is written to `cdb_*` and `cdb_valid` is set to 1. If it came from the queue, the queue is popped.
- **No grant.** `cdb_valid` is set to 0; `cdb_value`, `cdb_rob_id` and `cdb_src` hold their previous values.
- **Push rule.** A valid input is enqueued unless it was bypass-granted. Push and pop in the same cycle are legal and leave the count unchanged.
- **Input ordering.** A valid input is never bypass-granted while its queue is non-empty, so per-source FIFO order is preserved.
- **Full.**
  - A producer must not assert `*_valid` while its `*_full_out` is high.
  - If it does, the input is dropped, the count is unchanged, and `overflow_err` is set to 1.
  - `overflow_err` clears only on reset, not on flush.
- **Queue pointers.** Head/tail pointers are log2(QUEUE_DEPTH) bits and wrap naturally. The count is log2(QUEUE_DEPTH)+1 bits.
- **Flush.** `need_flush_in` clears both queues (pointers and counts to 0) and sets `cdb_valid` to 0. `last_grant` is set to 1 (memory), so the ALU wins the next tie. Inputs in the flush cycle are discarded.
- **`rdy_in` low.** No state changes; inputs are ignored.
- **Precedence.** `rst_in` > `rdy_in` low > `need_flush_in` > normal operation.

## Timing
- **Reset values.** `cdb_valid`=0, `cdb_value`=0, `cdb_rob_id`=0, `cdb_src`=0, `overflow_err`=0, `last_grant`=1, both counts 0. Consequently `alu_full_out`=0 and `mem_full_out`=0.
- **Latency.** A bypassed result captured at edge t is on the CDB during cycle t+1. A queued result appears one cycle after the edge that grants it.
- **Pulse width.** `cdb_valid` is high for exactly one cycle per grant. With continuous candidates the CDB carries one result every cycle, with no bubbles.
- **Starvation bound.** With both sources continuously pending, grants strictly alternate. The worst-case wait for a head-of-queue result is 1 cycle.
- **Full flags.** `*_full_out` reflects the registered count only. A pop in the current cycle does not deassert full until the next cycle.

## Structure
- **Shared header.** `src/const_param.v` gains `` `CDB_QUEUE_DEPTH `` (2). `` `ROB_SIZE_WIDTH `` is reused. The source-select encodings `CDB_SRC_ALU`=0 and `CDB_SRC_MEM`=1 are defined there.
- **Sub-module.** `cdb_queue` is instantiated twice: a QUEUE_DEPTH × (32+ROB_ID_WIDTH) circular buffer.
  - Inputs: push, pop, flush.
  - Outputs: head data, empty, full.
- **Top level.** Holds candidate selection, the round-robin register, the output registers and the error flag.

## Test plan
- **Solo ALU.** After reset, `alu_valid`=1 with value 0x11, tag 3 for one cycle → next cycle `cdb_valid`=1, value 0x11, tag 3, `cdb_src`=0; the ALU queue stays empty.
- **Simultaneous inputs.** ALU (0xA, tag 1) and memory (0xB, tag 2) in the same cycle after reset → cycle+1 broadcasts the ALU result, cycle+2 the memory result; then `cdb_valid`=0.
- **Sustained contention.** Both sources push every cycle for 8 cycles while respecting full → the CDB alternates ALU/memory with no bubbles; per-source tags come out in push order; full flags toggle and no overflow occurs.
- **Overflow.** Fill the memory queue to 2 by holding the ALU busy, then push memory again while `mem_full_out`=1 → the push is dropped and `overflow_err`=1; a later flush leaves `overflow_err`=1.
- **Flush mid-operation.** Both queues non-empty, assert `need_flush_in` → next cycle `cdb_valid`=0, both full flags 0; the next simultaneous pair grants the ALU first.
- **`rdy_in` low.** `rdy_in`=0 for 3 cycles with pending queues and live inputs → outputs and counts are frozen; on `rdy_in`=1 arbitration resumes with the same `last_grant`.
